// File: rtl/multi_pulse_gen.sv
// multi_pulse_gen: triggered burst of N gate pulses on k1 with dead-time-guarded complementary k2.
// The trigger is synchronised and edge-detected; burst configuration is latched at start.
module multi_pulse_gen #(
   parameter int CNT_W = 32,
   parameter int PN_W  = 8,
   parameter int DEAD  = 40
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             trig,
   input  logic [CNT_W-1:0] high_cycles,
   input  logic [CNT_W-1:0] low_cycles,
   input  logic [PN_W-1:0]  pulse_num,
   output logic             k1,
   output logic             k2,
   output logic             busy,
   output logic             done,
   output logic [PN_W-1:0]  pulse_idx
);
   typedef enum logic [1:0] {IDLE, HIGH, LOW, FINISH} state_t;
   localparam logic [CNT_W:0] DW = (CNT_W+1)'(DEAD);
   state_t state, state_n;
   logic s1, s2, s3;
   logic [CNT_W-1:0] cnt, h_len, l_len;
   logic [PN_W-1:0] n_len;
   logic trig_edge, start, h_end, l_end, last;
   assign trig_edge = s2 & ~s3;
   assign start = enable && trig_edge && pulse_num != '0;
   assign h_end = cnt == h_len - CNT_W'(1);
   assign l_end = cnt == l_len - CNT_W'(1);
   assign last = pulse_idx == n_len - PN_W'(1);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
         state <= IDLE;
         cnt <= '0;
         h_len <= '0;
         l_len <= '0;
         n_len <= '0;
         pulse_idx <= '0;
      end else begin
         s1 <= trig;
         s2 <= s1;
         s3 <= s2;
         state <= state_n;
         // count only while staying in a timed phase; any transition restarts at 0
         cnt <= (state_n == state && (state == HIGH || state == LOW)) ? cnt + CNT_W'(1) : '0;
         if (state == IDLE && state_n == HIGH) begin
            h_len <= (high_cycles == '0) ? CNT_W'(1) : high_cycles;
            l_len <= (low_cycles == '0) ? CNT_W'(1) : low_cycles;
            n_len <= pulse_num;
            pulse_idx <= '0;
         end else if (state == LOW && state_n == HIGH)
            pulse_idx <= pulse_idx + PN_W'(1);
      end
   end
   always_comb begin
      state_n = state;
      if (!enable)
         state_n = IDLE;
      else
         case (state)
            IDLE:    state_n = start ? HIGH : IDLE;
            HIGH:    state_n = h_end ? (last ? FINISH : LOW) : HIGH;
            LOW:     state_n = l_end ? HIGH : LOW;
            default: state_n = IDLE;
         endcase
   end
   // c + DEAD < L also covers L <= 2*DEAD, where the window is empty
   always_comb begin
      k1 = state == HIGH;
      k2 = state == LOW && {1'b0, cnt} >= DW && {1'b0, cnt} + DW < {1'b0, l_len};
      busy = state != IDLE;
      done = state == FINISH;
   end
endmodule

// File: tb/tb_multi_pulse_gen.sv
// tb_multi_pulse_gen: random and directed bursts; expected per-cycle outputs queued by
// the stimulus from a burst-level model, popped by a monitor whenever the DUT is active.
module tb_multi_pulse_gen;
   localparam int TB_DEAD = 1;
   logic clk = 1'b0, rst = 1'b1, enable = 1'b0, trig = 1'b0;
   logic [7:0] high_cycles = '0, low_cycles = '0;
   logic [3:0] pulse_num = '0;
   logic k1, k2, busy, done;
   logic [3:0] pulse_idx;
   int total = 0, bad = 0;
   logic [7:0] sb[$];
   logic [7:0] full[$];

   multi_pulse_gen #(.CNT_W(8), .PN_W(4), .DEAD(TB_DEAD)) dut (
      .clk(clk), .rst(rst), .enable(enable), .trig(trig),
      .high_cycles(high_cycles), .low_cycles(low_cycles), .pulse_num(pulse_num),
      .k1(k1), .k2(k2), .busy(busy), .done(done), .pulse_idx(pulse_idx)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      logic [7:0] e;
      if (!rst && (k1 || k2 || busy || done)) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_activity got=%b expected idle", {k1, k2, busy, done, pulse_idx});
         end else begin
            e = sb.pop_front();
            if ({k1, k2, busy, done, pulse_idx} !== e) begin
               bad++;
               $display("FAIL burst_cycle t=%0t got=%b want=%b", $time, {k1, k2, busy, done, pulse_idx}, e);
            end
         end
      end
   end

   // vector per active cycle: {k1,k2,busy,done,idx}
   task automatic build(input int h, input int l, input int n);
      int he, le;
      he = (h == 0) ? 1 : h;
      le = (l == 0) ? 1 : l;
      full.delete();
      for (int i = 0; i < n; i++) begin
         repeat (he) full.push_back({4'b1010, 4'(i)});
         if (i < n - 1)
            for (int c = 0; c < le; c++)
               full.push_back({1'b0, 1'(c >= TB_DEAD && c < le - TB_DEAD), 2'b10, 4'(i)});
      end
      full.push_back({4'b0011, 4'(n - 1)});
   endtask

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // mode: 0 full burst, 1 enable drop after m cycles, 2 reset after m cycles, 3 trig held through reset
   task automatic run(input int h, input int l, input int n, input int mode, input int m_in, input bit extra);
      int m, lat;
      logic [7:0] last;
      @(posedge clk); #1;
      high_cycles = 8'(h); low_cycles = 8'(l); pulse_num = 4'(n); enable = 1'b1;
      build(h, l, n);
      m = (mode == 1 || mode == 2) ? m_in : full.size();
      for (int i = 0; i < m; i++) sb.push_back(full[i]);
      last = full[m-1];
      if (mode == 3) begin
         rst = 1'b1; trig = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
      end else
         trig = 1'b1;
      lat = 0;
      while (!busy && lat < 20) begin @(negedge clk); lat++; end
      if (!busy) begin
         total++; bad++;
         $display("FAIL start_timeout got=busy0 want=busy1");
         sb.delete(); trig = 1'b0;
         return;
      end
      // trig set mid-cycle: the 3rd sampling edge is followed by the 4th falling edge
      if (mode != 3) check("start_latency", 8'(lat), 8'd4);
      high_cycles = 8'($urandom); low_cycles = 8'($urandom); pulse_num = 4'($urandom);
      for (int j = 1; j < m; j++) begin
         @(negedge clk);
         if (extra && j + 5 < m && j % 3 == 0) trig = ~trig;
      end
      if (mode == 1) enable = 1'b0;
      else if (mode == 2) begin
         #1 rst = 1'b1;
         #1 check("async_reset", {k1, k2, busy, done, pulse_idx}, 8'h00);
         @(posedge clk); #1;
         rst = 1'b0;
         last = '0;
      end
      trig = 1'b0;
      repeat (6) @(negedge clk);
      check("idx_hold", {4'h0, pulse_idx}, {4'h0, last[3:0]});
      enable = 1'b1;
   endtask

   task automatic zero_case();
      @(posedge clk); #1;
      pulse_num = '0; high_cycles = 8'd3; low_cycles = 8'd3; enable = 1'b1;
      repeat (3) begin
         trig = 1'b1;
         repeat (3) @(negedge clk);
         check("zero_pulses", {k1, k2, busy, done, 4'h0}, 8'h00);
         trig = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   initial begin
      int h, l, n, mode, sz, m;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", {k1, k2, busy, done, pulse_idx}, 8'h00);
      @(posedge clk); #1;
      rst = 1'b0;
      enable = 1'b1;
      repeat (3) @(negedge clk);
      run(4, 3, 2, 0, 0, 1'b0);
      run(4, 3, 2, 0, 0, 1'b1);
      run(0, 0, 3, 0, 0, 1'b0);
      run(10, 2, 1, 1, 5, 1'b0);
      run(3, 5, 4, 2, 5, 1'b0);
      run(2, 2, 2, 0, 0, 1'b0);
      zero_case();
      // edge arriving while disabled must be dropped
      @(posedge clk); #1;
      pulse_num = 4'd2; high_cycles = 8'd2; low_cycles = 8'd2; enable = 1'b0; trig = 1'b1;
      repeat (5) @(negedge clk);
      check("edge_while_disabled", {7'h0, busy}, 8'h00);
      trig = 1'b0;
      repeat (3) @(negedge clk);
      enable = 1'b1;
      run(3, 4, 2, 3, 0, 1'b0);
      run(255, 255, 2, 0, 0, 1'b0);
      for (int t = 0; t < 40; t++) begin
         h = $urandom_range(0, 6);
         l = $urandom_range(0, 8);
         n = $urandom_range(0, 4);
         mode = $urandom_range(0, 3);
         if (n == 0) zero_case();
         else begin
            sz = n * (h == 0 ? 1 : h) + (n - 1) * (l == 0 ? 1 : l) + 1;
            if ((mode == 1 || mode == 2) && sz < 2) mode = 0;
            m = (mode == 1 || mode == 2) ? $urandom_range(1, sz - 1) : 0;
            run(h, l, n, mode, m, 1'($urandom_range(0, 1)));
         end
      end
      repeat (5) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL leftover_expected got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
